// File: rtl/key_event_decoder_pkg.sv
// Shared key-event definitions: event codes and classifier state encodings.
// Imported by the key event decoder and by the countdown-timer control FSM.
package key_event_decoder_pkg;

    localparam int EVT_W = 3;

    localparam logic [EVT_W-1:0] EVT_NONE   = 3'd0;
    localparam logic [EVT_W-1:0] EVT_SHORT  = 3'd1;
    localparam logic [EVT_W-1:0] EVT_LONG   = 3'd2;
    localparam logic [EVT_W-1:0] EVT_REPEAT = 3'd3;
    localparam logic [EVT_W-1:0] EVT_DOUBLE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HELD     = 3'd1,
        ST_LONG     = 3'd2,
        ST_WAIT_DBL = 3'd3,
        ST_SWALLOW  = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous first-word-fall-through FIFO for key events.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key activity into SHORT/LONG/REPEAT events and queues them.
// Define KEY_DEC_DOUBLE_CLICK_EN to add DOUBLE detection (WAIT_DBL/SWALLOW states).
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int LONG_PRESS_TICKS = 500,
    parameter int DBL_WINDOW_TICKS = 250,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic             KEY_UP,
    input  logic             KEY_EN,
    input  logic             EVT_READY,
    input  logic             OVF_CLR,
    output logic             EVT_VALID,
    output logic [EVT_W-1:0] EVT_CODE,
    output logic             OVF
);

    if (LONG_PRESS_TICKS < 2) begin : g_bad_long
        $error("LONG_PRESS_TICKS must be at least 2");
    end
    if (DBL_WINDOW_TICKS < 1) begin : g_bad_dbl
        $error("DBL_WINDOW_TICKS must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    localparam int               HOLD_W    = $clog2(LONG_PRESS_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_TICKS - 1);

    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == {HOLD_W{1'b1}}) ? v : v + HOLD_W'(1);
    endfunction

    key_state_t       state;
    key_state_t       state_nxt;
    logic             key_en_q;
    logic             press_edge;
    logic             rpt_pulse;
    logic             release_evt;
    logic [HOLD_W-1:0] hold_cnt;
    logic             hold_clr;
    logic             hold_inc;
    logic             long_hit;
    logic             push;
    logic [EVT_W-1:0] push_code;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EVT_W-1:0] fifo_dout;

`ifdef KEY_DEC_DOUBLE_CLICK_EN
    localparam int               WIN_W    = $clog2(DBL_WINDOW_TICKS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DBL_WINDOW_TICKS - 1);

    function automatic logic [WIN_W-1:0] win_sat_inc(input logic [WIN_W-1:0] v);
        return (v == {WIN_W{1'b1}}) ? v : v + WIN_W'(1);
    endfunction

    logic [WIN_W-1:0] win_cnt;
    logic             win_clr;
    logic             win_inc;
    logic             win_expire;

    assign win_expire = CE && (win_cnt == WIN_LAST);

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N)       win_cnt <= '0;
        else if (win_clr) win_cnt <= '0;
        else if (win_inc) win_cnt <= win_sat_inc(win_cnt);
    end
`endif

    assign press_edge  = KEY_UP & ~KEY_EN;
    assign rpt_pulse   = KEY_UP & KEY_EN;
    assign release_evt = key_en_q & ~KEY_EN;
    // Threshold is taken on the tick that would bring hold_cnt to LONG_PRESS_TICKS.
    assign long_hit    = CE && (hold_cnt == HOLD_LAST);

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state    <= ST_IDLE;
            key_en_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            key_en_q <= KEY_EN;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N)        hold_cnt <= '0;
        else if (hold_clr) hold_cnt <= '0;
        else if (hold_inc) hold_cnt <= hold_sat_inc(hold_cnt);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (press_edge) state_nxt = ST_HELD;
            ST_HELD: begin
                if (release_evt) begin
`ifdef KEY_DEC_DOUBLE_CLICK_EN
                    state_nxt = ST_WAIT_DBL;
`else
                    state_nxt = ST_IDLE;
`endif
                end else if (long_hit) begin
                    state_nxt = ST_LONG;
                end
            end
            ST_LONG: if (release_evt) state_nxt = ST_IDLE;
`ifdef KEY_DEC_DOUBLE_CLICK_EN
            ST_WAIT_DBL: begin
                if (press_edge)      state_nxt = ST_SWALLOW;
                else if (win_expire) state_nxt = ST_IDLE;
            end
            ST_SWALLOW: if (release_evt) state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        push_code = EVT_NONE;
        hold_clr  = 1'b0;
        hold_inc  = 1'b0;
`ifdef KEY_DEC_DOUBLE_CLICK_EN
        win_clr   = 1'b0;
        win_inc   = 1'b0;
`endif
        case (state)
            ST_IDLE: hold_clr = press_edge;
            ST_HELD: begin
                hold_inc = CE;
                if (release_evt) begin
`ifdef KEY_DEC_DOUBLE_CLICK_EN
                    win_clr   = 1'b1;
`else
                    push      = 1'b1;
                    push_code = EVT_SHORT;
`endif
                end else if (long_hit) begin
                    push      = 1'b1;
                    push_code = EVT_LONG;
                end
            end
            ST_LONG: begin
                if (rpt_pulse) begin
                    push      = 1'b1;
                    push_code = EVT_REPEAT;
                end
            end
`ifdef KEY_DEC_DOUBLE_CLICK_EN
            ST_WAIT_DBL: begin
                win_inc = CE;
                if (press_edge) begin
                    push      = 1'b1;
                    push_code = EVT_DOUBLE;
                end else if (win_expire) begin
                    push      = 1'b1;
                    push_code = EVT_SHORT;
                end
            end
`endif
            default: ;
        endcase
    end

    assign pop  = EVT_VALID & EVT_READY;
    assign drop = push & fifo_full & ~pop;

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .push  (push),
        .pop   (pop),
        .din   (push_code),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign EVT_VALID = ~fifo_empty;
    assign EVT_CODE  = fifo_empty ? EVT_NONE : fifo_dout;

    // A drop in the same cycle as OVF_CLR keeps the flag set.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N)       OVF <= 1'b0;
        else if (drop)    OVF <= 1'b1;
        else if (OVF_CLR) OVF <= 1'b0;
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: vector table plus hand-written corner sequences.
// Expected events go into a queue when stimulus is driven and are compared as the DUT pops them.
module tb_key_event_decoder;
    import key_event_decoder_pkg::*;

    localparam int LONG_T = 8;
    localparam int DBL_T  = 6;
    localparam int DEPTH  = 4;

    logic       CLK = 1'b0;
    logic       CLR_N = 1'b0;
    logic       CE = 1'b0;
    logic       KEY_UP = 1'b0;
    logic       KEY_EN = 1'b0;
    logic       EVT_READY = 1'b0;
    logic       OVF_CLR = 1'b0;
    logic       EVT_VALID;
    logic [2:0] EVT_CODE;
    logic       OVF;

    int         compared = 0;
    int         mismatched = 0;
    int         valid_cycles = 0;
    int         pops = 0;
    int         ce_div = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;

    typedef struct {
        int         hold;
        int         n_rpt;
        logic [2:0] first;
    } vec_t;
    vec_t vecs[6];

    key_event_decoder #(
        .LONG_PRESS_TICKS (LONG_T),
        .DBL_WINDOW_TICKS (DBL_T),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .CLK       (CLK),
        .CLR_N     (CLR_N),
        .CE        (CE),
        .KEY_UP    (KEY_UP),
        .KEY_EN    (KEY_EN),
        .EVT_READY (EVT_READY),
        .OVF_CLR   (OVF_CLR),
        .EVT_VALID (EVT_VALID),
        .EVT_CODE  (EVT_CODE),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    // CE strobe on every 4th clock, changed just after the rising edge.
    always @(posedge CLK) begin
        #1;
        ce_div = (ce_div + 1) % 4;
        CE = (ce_div == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (CLR_N && EVT_VALID) valid_cycles++;
        if (CLR_N && EVT_VALID && EVT_READY) begin
            pops++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: got code %0d, required no event", EVT_CODE);
            end else begin
                mon_exp = exp_q.pop_front();
                check("evt_code", {29'd0, EVT_CODE}, {29'd0, mon_exp});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge CLK);
            while (CE !== 1'b1) @(posedge CLK);
        end
        #1;
    endtask

    task automatic do_press();
        @(posedge CLK); #1;
        KEY_UP = 1'b1; KEY_EN = 1'b0;
        @(posedge CLK); #1;
        KEY_UP = 1'b0; KEY_EN = 1'b1;
    endtask

    task automatic do_release();
        KEY_EN = 1'b0;
        cyc(1);
    endtask

    task automatic rpt();
        KEY_UP = 1'b1;
        cyc(1);
        KEY_UP = 1'b0;
    endtask

    task automatic settle();
        wait_ticks(DBL_T + 4);
    endtask

    task automatic drain_wait(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge CLK);
            n++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic short_press(input int ticks);
        do_press();
        wait_ticks(ticks);
        do_release();
        settle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1);
    end

    initial begin
        int v0;
        int p0;

        vecs[0] = '{hold: 3,  n_rpt: 0, first: EVT_SHORT};
        vecs[1] = '{hold: 1,  n_rpt: 0, first: EVT_SHORT};
        vecs[2] = '{hold: 7,  n_rpt: 0, first: EVT_SHORT};
        vecs[3] = '{hold: 8,  n_rpt: 0, first: EVT_LONG};
        vecs[4] = '{hold: 20, n_rpt: 3, first: EVT_LONG};
        vecs[5] = '{hold: 12, n_rpt: 1, first: EVT_LONG};

        // Reset state
        cyc(3);
        check("rst_valid", EVT_VALID, 0);
        check("rst_code", EVT_CODE, 0);
        check("rst_ovf", OVF, 0);
        CLR_N = 1'b1;
        cyc(2);

`ifndef KEY_DEC_DOUBLE_CLICK_EN
        // One-cycle push-to-valid latency
        EVT_READY = 1'b0;
        exp_q.push_back(EVT_SHORT);
        do_press();
        wait_ticks(3);
        KEY_EN = 1'b0;
        @(negedge CLK);
        check("lat_before", EVT_VALID, 0);
        @(negedge CLK);
        check("lat_valid", EVT_VALID, 1);
        check("lat_code", EVT_CODE, EVT_SHORT);
        @(posedge CLK); #1;
        EVT_READY = 1'b1;
        drain_wait("lat_drain");
        cyc(2);
`endif

        // Vector table: hold length, repeat pulses, first expected code
        EVT_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cycles;
            exp_q.push_back(vecs[i].first);
            for (int r = 0; r < vecs[i].n_rpt; r++) exp_q.push_back(EVT_REPEAT);
            do_press();
            if (vecs[i].n_rpt == 0) begin
                wait_ticks(vecs[i].hold);
            end else begin
                wait_ticks(10);
                for (int r = 0; r < vecs[i].n_rpt; r++) begin
                    rpt();
                    wait_ticks(2);
                end
                wait_ticks(vecs[i].hold - 10 - 2 * vecs[i].n_rpt);
            end
            do_release();
            settle();
            drain_wait($sformatf("vec%0d_drain", i));
            check($sformatf("vec%0d_valid_cycles", i), valid_cycles - v0, 1 + vecs[i].n_rpt);
            check($sformatf("vec%0d_idle", i), EVT_VALID, 0);
        end

        // Overflow: five presses into a four-deep queue with no consumer
        EVT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(EVT_SHORT);
            short_press(2);
        end
        check("ovf_set", OVF, 1);
        check("ovf_full_valid", EVT_VALID, 1);
        p0 = pops;
        EVT_READY = 1'b1;
        drain_wait("ovf_drain");
        cyc(3);
        check("ovf_pops", pops - p0, 4);
        check("ovf_empty", EVT_VALID, 0);
        check("ovf_sticky", OVF, 1);
        OVF_CLR = 1'b1;
        cyc(1);
        OVF_CLR = 1'b0;
        check("ovf_clr", OVF, 0);

        // Release on the threshold tick: SHORT wins over LONG
        exp_q.push_back(EVT_SHORT);
        do_press();
        wait_ticks(LONG_T - 1);
        #1;
        while (CE !== 1'b1) begin
            @(posedge CLK); #2;
        end
        KEY_EN = 1'b0;
        cyc(1);
        settle();
        drain_wait("thr_drain");

        // Full queue with push and pop in the same cycle: no drop
        EVT_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(EVT_SHORT);
            short_press(2);
        end
        exp_q.push_back(EVT_SHORT);
        p0 = pops;
        do_press();
        wait_ticks(2);
`ifdef KEY_DEC_DOUBLE_CLICK_EN
        do_release();
        wait_ticks(DBL_T - 1);
        #1;
        while (CE !== 1'b1) begin
            @(posedge CLK); #2;
        end
        EVT_READY = 1'b1;
        cyc(1);
`else
        EVT_READY = 1'b1;
        KEY_EN = 1'b0;
        cyc(1);
`endif
        EVT_READY = 1'b0;
        cyc(2);
        check("pp_one_pop", pops - p0, 1);
        check("pp_ovf", OVF, 0);
        check("pp_valid", EVT_VALID, 1);
        EVT_READY = 1'b1;
        drain_wait("pp_drain");
        cyc(2);
        check("pp_total_pops", pops - p0, 5);
        check("pp_ovf_after", OVF, 0);

        // Reset while held: no event until a fresh press edge
        v0 = valid_cycles;
        do_press();
        wait_ticks(3);
        CLR_N = 1'b0;
        cyc(2);
        check("mid_rst_valid", EVT_VALID, 0);
        check("mid_rst_code", EVT_CODE, 0);
        check("mid_rst_ovf", OVF, 0);
        CLR_N = 1'b1;
        wait_ticks(LONG_T + 4);
        rpt();
        wait_ticks(2);
        do_release();
        settle();
        check("mid_rst_no_evt", valid_cycles - v0, 0);
        exp_q.push_back(EVT_SHORT);
        short_press(2);
        drain_wait("mid_rst_fresh");
        check("mid_rst_fresh_cycles", valid_cycles - v0, 1);

`ifdef KEY_DEC_DOUBLE_CLICK_EN
        // Second press inside the window forms one DOUBLE; the rest of that hold is swallowed
        v0 = valid_cycles;
        exp_q.push_back(EVT_DOUBLE);
        do_press();
        wait_ticks(2);
        do_release();
        wait_ticks(3);
        do_press();
        wait_ticks(LONG_T + 4);
        rpt();
        wait_ticks(2);
        do_release();
        settle();
        drain_wait("dbl_drain");
        check("dbl_cycles", valid_cycles - v0, 1);

        // Second press after the window: two separate SHORTs
        v0 = valid_cycles;
        exp_q.push_back(EVT_SHORT);
        exp_q.push_back(EVT_SHORT);
        do_press();
        wait_ticks(2);
        do_release();
        wait_ticks(DBL_T + 1);
        short_press(2);
        drain_wait("dbl_late_drain");
        check("dbl_late_cycles", valid_cycles - v0, 2);
`endif

        cyc(4);
        check("final_queue", exp_q.size(), 0);
        check("final_valid", EVT_VALID, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
